// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns IR, sequences FETCH/DECODE/EXECUTE/
// MEM/WRITEBACK/HALTED, arbitrates the memory port and times out waits.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   instr_in             instruction word, latched on mem_ready in FETCH
//   mem_ready            memory access complete this cycle
//   resume               leave HALTED (level)
//   mem_req/mem_sel_data memory request / address select (1 = ALU result)
//   mem_we               memory write strobe (STOR)
//   ir                   latched instruction
//   alu_en/rf_we/pc_en   datapath enables
//   soft_reset           one-cycle pulse after a RESET instruction decodes
//   halted/bus_error     HALTED state / sticky memory timeout flag
//   retire_count         retired instructions, wraps
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr_in,
  input  logic        mem_ready,
  input  logic        resume,
  output logic        mem_req,
  output logic        mem_sel_data,
  output logic        mem_we,
  output logic [15:0] ir,
  output logic        alu_en,
  output logic        rf_we,
  output logic        pc_en,
  output logic        soft_reset,
  output logic        halted,
  output logic        bus_error,
  output logic [15:0] retire_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t          r_state;
  logic [15:0]     r_ir;
  logic [15:0]     r_retire;
  logic [TO_W-1:0] r_wait;
  logic            r_bus_err;
  logic            r_soft_rst;
  // Set when WRITEBACK is entered from HALTED; suppresses rf_we there.
  logic            r_from_halt;

  logic [3:0]  w_op;
  logic [11:0] w_sub;
  logic        w_ctrl;
  logic        w_halt;
  logic        w_rst;
  logic        w_stcb;
  logic        w_wb_cls;
  logic        w_alu_cls;
  logic        w_mem_cls;
  logic        w_stor;
  logic        w_to;

  assign w_op      = r_ir[15:12];
  assign w_sub     = r_ir[11:0];
  assign w_ctrl    = (w_op == 4'hF);
  assign w_halt    = w_ctrl && (w_sub == 12'hFFF);
  assign w_rst     = w_ctrl && (w_sub == 12'hAAA);
  assign w_stcb    = w_ctrl &&
                     ((w_sub == 12'h001) || (w_sub == 12'h002));
  assign w_wb_cls  = (w_op inside {4'h1, 4'h2, 4'h3,
                                   4'h4, 4'h5, 4'h6});
  assign w_alu_cls = (w_op inside {4'h1, 4'h2, 4'h4,
                                   4'h5, 4'h6, 4'h7}) || w_stcb;
  assign w_mem_cls = (w_op == 4'h6) || (w_op == 4'h7);
  assign w_stor    = (w_op == 4'h7);
  assign w_to      = (r_wait == TO_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_ir        <= 16'h0000;
      r_retire    <= 16'h0000;
      r_wait      <= '0;
      r_bus_err   <= 1'b0;
      r_soft_rst  <= 1'b0;
      r_from_halt <= 1'b0;
    end else begin
      r_soft_rst <= 1'b0;
      unique case (r_state)
        S_FETCH: begin
          // mem_ready wins over a coincident timeout
          if (mem_ready) begin
            r_ir    <= instr_in;
            r_wait  <= '0;
            r_state <= S_DECODE;
          end else if (w_to) begin
            r_bus_err <= 1'b1;
            r_wait    <= '0;
            r_state   <= S_HALT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_DECODE: begin
          r_wait <= '0;
          if (w_halt) begin
            r_state <= S_HALT;
          end else if (w_rst) begin
            r_soft_rst <= 1'b1;
            r_state    <= S_FETCH;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_wait  <= '0;
          r_state <= w_mem_cls ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            r_wait  <= '0;
            r_state <= S_WB;
          end else if (w_to) begin
            r_bus_err <= 1'b1;
            r_wait    <= '0;
            r_state   <= S_HALT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_WB: begin
          r_wait      <= '0;
          r_retire    <= r_retire + 16'h0001;
          r_from_halt <= 1'b0;
          r_state     <= S_FETCH;
        end
        S_HALT: begin
          r_wait <= '0;
          if (resume) begin
            r_bus_err   <= 1'b0;
            r_from_halt <= 1'b1;
            r_state     <= S_WB;
          end
        end
        default: begin
          r_wait  <= '0;
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  // Outputs are decoded from state/ir and held at 0 while reset is high.
  assign mem_req      = !reset &&
                        ((r_state == S_FETCH) || (r_state == S_MEM));
  assign mem_sel_data = !reset && (r_state == S_MEM);
  assign mem_we       = !reset && (r_state == S_MEM) && w_stor;
  assign alu_en       = !reset && (r_state == S_EXEC) && w_alu_cls;
  assign rf_we        = !reset && (r_state == S_WB) &&
                        w_wb_cls && !r_from_halt;
  assign pc_en        = !reset && (r_state == S_WB);
  assign halted       = !reset && (r_state == S_HALT);
  assign soft_reset   = !reset && r_soft_rst;
  assign bus_error    = !reset && r_bus_err;
  assign ir           = reset ? 16'h0000 : r_ir;
  assign retire_count = reset ? 16'h0000 : r_retire;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: instruction classes, memory waits,
// HALT/RESET handling, timeouts and mid-access reset.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr_in;
  logic        mem_ready;
  logic        resume;
  logic        mem_req;
  logic        mem_sel_data;
  logic        mem_we;
  logic [15:0] ir;
  logic        alu_en;
  logic        rf_we;
  logic        pc_en;
  logic        soft_reset;
  logic        halted;
  logic        bus_error;
  logic [15:0] retire_count;

  int n_vec = 0;
  int n_err = 0;

  // {req, sel, we, alu, rf, pc, srst, halted}
  logic [7:0] w_outs;
  assign w_outs = {mem_req, mem_sel_data, mem_we, alu_en,
                   rf_we, pc_en, soft_reset, halted};

  always #5 clk = ~clk;

  cpu_sequencer #(
    .MEM_TIMEOUT(15),
    .TO_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .instr_in(instr_in),
    .mem_ready(mem_ready),
    .resume(resume),
    .mem_req(mem_req),
    .mem_sel_data(mem_sel_data),
    .mem_we(mem_we),
    .ir(ir),
    .alu_en(alu_en),
    .rf_we(rf_we),
    .pc_en(pc_en),
    .soft_reset(soft_reset),
    .halted(halted),
    .bus_error(bus_error),
    .retire_count(retire_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [7:0] exp, input string tag);
    tick();
    chk(tag, {8'h00, w_outs}, {8'h00, exp});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    instr_in  = 16'h0000;
    mem_ready = 1'b0;
    resume    = 1'b0;
    tick();
    tick();
    chk("rst_outs", {8'h00, w_outs}, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_ret", retire_count, 16'h0000);
    chk("rst_berr", {15'd0, bus_error}, 16'h0000);
    reset = 1'b0;
    #1;
    chk("rel_fetch", {8'h00, w_outs}, 16'h0080);

    // ADDI, zero-wait
    instr_in  = 16'h4A45;
    mem_ready = 1'b1;
    step(8'h00, "addi_dec");
    mem_ready = 1'b0;
    chk("addi_ir", ir, 16'h4A45);
    step(8'h10, "addi_exe");
    step(8'h0C, "addi_wb");
    chk("addi_ret_wb", retire_count, 16'h0000);
    step(8'h80, "addi_fetch");
    chk("addi_ret", retire_count, 16'h0001);

    // LOAD, 2 wait cycles in MEM
    instr_in  = 16'h6123;
    mem_ready = 1'b1;
    step(8'h00, "ld_dec");
    mem_ready = 1'b0;
    step(8'h10, "ld_exe");
    step(8'hC0, "ld_mem1");
    step(8'hC0, "ld_mem2");
    step(8'hC0, "ld_mem3");
    mem_ready = 1'b1;
    step(8'h0C, "ld_wb");
    mem_ready = 1'b0;
    step(8'h80, "ld_fetch");
    chk("ld_ret", retire_count, 16'h0002);

    // STOR, 2 wait cycles in MEM
    instr_in  = 16'h7456;
    mem_ready = 1'b1;
    step(8'h00, "st_dec");
    mem_ready = 1'b0;
    step(8'h10, "st_exe");
    step(8'hE0, "st_mem1");
    step(8'hE0, "st_mem2");
    step(8'hE0, "st_mem3");
    mem_ready = 1'b1;
    step(8'h04, "st_wb");
    mem_ready = 1'b0;
    step(8'h80, "st_fetch");
    chk("st_ret", retire_count, 16'h0003);

    // HALT then resume; mem_ready while halted is ignored
    instr_in  = 16'hFFFF;
    mem_ready = 1'b1;
    step(8'h00, "hlt_dec");
    step(8'h01, "hlt_h1");
    mem_ready = 1'b0;
    step(8'h01, "hlt_h2");
    step(8'h01, "hlt_h3");
    resume = 1'b1;
    step(8'h04, "hlt_wb");
    resume = 1'b0;
    step(8'h80, "hlt_fetch");
    chk("hlt_ret", retire_count, 16'h0004);

    // RESET instruction
    instr_in  = 16'hFAAA;
    mem_ready = 1'b1;
    step(8'h00, "srst_dec");
    mem_ready = 1'b0;
    step(8'h82, "srst_pulse");
    chk("srst_ret", retire_count, 16'h0004);

    // NOP
    instr_in  = 16'h0000;
    mem_ready = 1'b1;
    step(8'h00, "nop_dec");
    mem_ready = 1'b0;
    step(8'h00, "nop_exe");
    step(8'h04, "nop_wb");
    step(8'h80, "nop_fetch");
    chk("nop_ret", retire_count, 16'h0005);

    // Fetch timeout: 15 FETCH cycles without mem_ready
    instr_in = 16'h1234;
    for (int i = 0; i < 13; i++) tick();
    step(8'h80, "fto_f15");
    step(8'h01, "fto_halt");
    chk("fto_berr", {15'd0, bus_error}, 16'h0001);
    chk("fto_ir", ir, 16'h0000);
    resume = 1'b1;
    step(8'h04, "fto_wb");
    resume = 1'b0;
    chk("fto_clr", {15'd0, bus_error}, 16'h0000);
    step(8'h80, "fto_fetch");
    chk("fto_ret", retire_count, 16'h0006);

    // LOAD timing out in MEM; resume must not write the RF
    instr_in  = 16'h6000;
    mem_ready = 1'b1;
    step(8'h00, "mto_dec");
    mem_ready = 1'b0;
    step(8'h10, "mto_exe");
    step(8'hC0, "mto_m1");
    for (int i = 0; i < 13; i++) tick();
    step(8'hC0, "mto_m15");
    step(8'h01, "mto_halt");
    chk("mto_berr", {15'd0, bus_error}, 16'h0001);
    resume = 1'b1;
    step(8'h04, "mto_wb");
    resume = 1'b0;
    step(8'h80, "mto_fetch");
    chk("mto_ret", retire_count, 16'h0007);

    // mem_ready on the 15th FETCH cycle wins over the timeout
    instr_in = 16'h1234;
    for (int i = 0; i < 14; i++) tick();
    mem_ready = 1'b1;
    step(8'h00, "co_dec");
    mem_ready = 1'b0;
    chk("co_berr", {15'd0, bus_error}, 16'h0000);
    chk("co_ir", ir, 16'h1234);
    step(8'h10, "co_exe");
    step(8'h0C, "co_wb");
    step(8'h80, "co_fetch");
    chk("co_ret", retire_count, 16'h0008);

    // Reset during STOR MEM
    instr_in  = 16'h7456;
    mem_ready = 1'b1;
    step(8'h00, "mr_dec");
    mem_ready = 1'b0;
    step(8'h10, "mr_exe");
    step(8'hE0, "mr_mem");
    reset = 1'b1;
    #1;
    chk("mr_rst0", {8'h00, w_outs}, 16'h0000);
    step(8'h00, "mr_rst1");
    chk("mr_rst_ir", ir, 16'h0000);
    reset = 1'b0;
    #1;
    chk("mr_rel", {8'h00, w_outs}, 16'h0080);
    chk("mr_ir", ir, 16'h0000);
    chk("mr_ret", retire_count, 16'h0000);
    instr_in  = 16'h4A45;
    mem_ready = 1'b1;
    step(8'h00, "mr2_dec");
    mem_ready = 1'b0;
    step(8'h10, "mr2_exe");
    step(8'h0C, "mr2_wb");
    step(8'h80, "mr2_fetch");
    chk("mr2_ret", retire_count, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the 16-bit processor datapath. Owns the instruction register and sequences fetch, decode, execute, memory and writeback. Drives the per-cycle enables for the program counter, ALU and register file. Arbitrates a single-port memory between instruction fetch and LOAD/STOR data access, enforces a memory-wait timeout, and handles the HALT and RESET control instructions.

Parameters:
MEM_TIMEOUT, 15, max cycles to wait for mem_ready in FETCH or MEM before a bus error (1..2^TO_W-1)
TO_W, 4, width of the wait counter

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
instr_in  in  16  instruction word from memory, sampled when mem_ready is high in FETCH
mem_ready  in  1  memory access complete this cycle
resume  in  1  leave HALTED (level, sampled only in HALTED)
mem_req  out  1  memory access request
mem_sel_data  out  1  address mux select: 0 = PC (fetch), 1 = ALU result (load/store)
mem_we  out  1  memory write strobe (STOR only)
ir  out  16  latched instruction; feeds instruction_decode
alu_en  out  1  ALU clock enable (carry/borrow update)
rf_we  out  1  register-file write enable
pc_en  out  1  program-counter clock enable, one-cycle pulse
soft_reset  out  1  one-cycle pulse on the RESET instruction
halted  out  1  high in HALTED
bus_error  out  1  sticky memory-timeout flag
retire_count  out  16  instructions retired, wraps 0xFFFF->0

Behaviour:
- Internal decode uses ir[15:12] as opcode. The control group is 1111 with subcode ir[11:0]: HALT=FFF, RESET=AAA, STC=001, STB=002, RETURN=000.
- WB class (rf_we in WRITEBACK): 0001, 0010, 0011, 0100, 0101, 0110.
- ALU class (alu_en in EXECUTE): 0001, 0010, 0100, 0101, 0110, 0111, plus STC/STB.
- MEM class: 0110 LOAD (read), 0111 STOR (write).
- All other opcodes (NOP, branches, J, JL, INT, RETURN, unknown control subcode) use EXECUTE->WRITEBACK with only pc_en.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALTED. Moore outputs are decoded from state and ir. soft_reset is registered.
- FETCH: mem_req=1, mem_sel_data=0. On mem_ready, ir<=instr_in and go to DECODE. Otherwise increment wait_cnt.
- DECODE: no strobes, 1 cycle.
  - HALT -> HALTED.
  - RESET -> soft_reset=1 on the next cycle, go to FETCH, retire_count unchanged. The external PC clears on soft_reset.
  - Otherwise -> EXECUTE.
- EXECUTE: alu_en per class, 1 cycle. MEM class -> MEM, else -> WRITEBACK.
- MEM: mem_req=1, mem_sel_data=1, mem_we=1 for STOR only. On mem_ready go to WRITEBACK. Otherwise increment wait_cnt.
- WRITEBACK: pc_en=1, rf_we per class, retire_count+=1, go to FETCH.
- HALTED: halted=1, all strobes 0. When resume=1: clear bus_error, go to WRITEBACK (rf_we=0, PC steps past HALT, retires). WRITEBACK never asserts rf_we after HALTED.
- Timeout: wait_cnt clears on every state entry. If wait_cnt==MEM_TIMEOUT-1 and mem_ready=0 in FETCH or MEM: set bus_error, go to HALTED, drop mem_req next cycle. A store does not complete, and ir is unchanged on a fetch timeout.
- If mem_ready and the timeout coincide, mem_ready wins and there is no error.
- Latency with zero-wait memory: non-memory instruction 4 cycles, LOAD/STOR 5 cycles, RESET 2 cycles plus the pulse, HALT->HALTED 2 cycles.
- Reset (any state, mid-access): state=FETCH, ir=0, wait_cnt=0, retire_count=0, bus_error=0, soft_reset=0. All outputs read 0 during the reset cycle. mem_req=1 on the first cycle after release.
- mem_ready outside FETCH/MEM is ignored. resume outside HALTED is ignored.
- retire_count wraps silently.

Test Plan:
- ADDI (0x4A45), zero-wait memory -> pc_en pulses once per 4 cycles. alu_en in cycle 3, rf_we and pc_en in cycle 4. retire_count=1.
- LOAD then STOR, each with 2 wait cycles in MEM -> mem_sel_data=1 during MEM. mem_we=0 for LOAD, 1 for STOR. rf_we only for LOAD. 7 cycles each.
- HALT (0xFFFF) -> halted=1 from cycle 3, no pc_en while resume=0. resume=1 -> one pc_en with rf_we=0, halted=0, retire_count increments.
- RESET (0xFAAA) -> soft_reset high exactly 1 cycle after DECODE, then FETCH. No pc_en or rf_we pulse. retire_count unchanged.
- mem_ready held low in FETCH with MEM_TIMEOUT=15 -> bus_error=1 and halted=1 after 15 FETCH cycles. mem_ready rising on cycle 15 instead -> no error, DECODE follows.
- Reset asserted mid-MEM of a STOR -> next cycle all outputs 0, ir=0, then fetch restarts. No mem_we seen after the reset cycle.
